// File: rtl/root_quotient_div_pkg.sv
// Fixed-point constants and FSM state type shared by the n-th-root stage and the quotient divider.
package root_quotient_div_pkg;

    localparam int INT_W  = 10;
    localparam int FRAC_W = 10;
    localparam int DW     = INT_W + FRAC_W;
    localparam int NW     = DW + FRAC_W;
    localparam int CNT_W  = 5;

    localparam logic [DW-1:0]    Q_ONE    = 20'h00400;
    localparam logic [DW-1:0]    Q_SAT    = 20'hFFFFF;
    localparam logic [CNT_W-1:0] LAST_CNT = 5'd29;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/root_quotient_div_step.sv
// One radix-2 restoring division step: shift in the next numerator bit, subtract the divisor if it fits.
module restoring_div_step
    import root_quotient_div_pkg::*;
(
    input  logic [DW:0]   r_i,
    input  logic [DW-1:0] divisor_i,
    input  logic          n_bit_i,
    output logic [DW:0]   r_o,
    output logic          q_bit_o
);

    logic [DW:0] shifted;
    logic [DW:0] divisorExt;

    always_comb begin
        shifted    = {r_i[DW-1:0], n_bit_i};
        divisorExt = {1'b0, divisor_i};
        r_o        = shifted;
        q_bit_o    = 1'b0;
        if (shifted >= divisorExt) begin
            r_o     = shifted - divisorExt;
            q_bit_o = 1'b1;
        end
    end

endmodule

// File: rtl/root_quotient_div.sv
// Sequential Q10.10 divider: 30 restoring steps per operation, truncated and saturated quotient.
module root_quotient_div
    import root_quotient_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data_1,
    input  logic [DW-1:0] in_data_2,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sat,
    output logic          out_dbz,
    output logic          overrun
);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NW-1:0]   n_q, n_d;
    logic [NW-1:0]   q_q, q_d;
    logic [DW:0]     r_q, r_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic            outValid_q, outValid_d;
    logic [DW-1:0]   outData_q, outData_d;
    logic            outSat_q, outSat_d;
    logic            outDbz_q, outDbz_d;
    logic            overrun_q, overrun_d;

    logic [DW:0]     stepR;
    logic            stepQ;
    logic [NW-1:0]   qFinal;

    restoring_div_step u_step (
        .r_i       (r_q),
        .divisor_i (dvs_q),
        .n_bit_i   (n_q[NW-1]),
        .r_o       (stepR),
        .q_bit_o   (stepQ)
    );

    assign qFinal = {q_q[NW-2:0], stepQ};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            dvs_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSat_q   <= 1'b0;
            outDbz_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            q_q        <= q_d;
            r_q        <= r_d;
            dvs_q      <= dvs_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSat_q   <= outSat_d;
            outDbz_q   <= outDbz_d;
            overrun_q  <= overrun_d;
        end
    end

    // Result registers default to zero so the outputs are only non-zero during the DONE cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        q_d        = q_q;
        r_d        = r_q;
        dvs_d      = dvs_q;
        outValid_d = 1'b0;
        outData_d  = '0;
        outSat_d   = 1'b0;
        outDbz_d   = 1'b0;
        overrun_d  = overrun_q | (in_valid & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    n_d   = {in_data_1, {FRAC_W{1'b0}}};
                    q_d   = '0;
                    r_d   = '0;
                    dvs_d = in_data_2;
                    cnt_d = '0;
                    if (in_data_2 == '0) begin
                        state_d    = ST_DONE;
                        outValid_d = 1'b1;
                        outData_d  = Q_SAT;
                        outDbz_d   = 1'b1;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                r_d   = stepR;
                n_d   = {n_q[NW-2:0], 1'b0};
                q_d   = qFinal;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d    = ST_DONE;
                    outValid_d = 1'b1;
                    if (qFinal[NW-1:DW] != '0) begin
                        outData_d = Q_SAT;
                        outSat_d  = 1'b1;
                    end else begin
                        outData_d = qFinal[DW-1:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sat   = outSat_q;
    assign out_dbz   = outDbz_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_root_quotient_div.sv
// Directed-vector bench for root_quotient_div; inputs driven and outputs sampled on the falling edge.
module tb_root_quotient_div;
    import root_quotient_div_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data_1;
    logic [DW-1:0] in_data_2;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sat;
    logic          out_dbz;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    root_quotient_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_dbz   (out_dbz),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            lat;
        logic [DW-1:0] data;
        logic          sat;
        logic          dbz;
        logic          startReady;
        logic          readyDone;
        logic          readyAfter;
        logic          validAfter;
        logic [DW-1:0] dataAfter;
        logic          dirty;
    } obs_t;

    // Launches one operation from a falling edge and records what the DUT shows around its result.
    // Latency is counted so that the first edge after operand capture is T+1.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int injectAt, input bit injectDone, output obs_t o);
        int k;
        o.lat = -1; o.data = 'x; o.sat = 'x; o.dbz = 'x; o.readyDone = 'x; o.dirty = 1'b0;
        o.startReady = in_ready;
        in_valid = 1'b1; in_data_1 = a; in_data_2 = b;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_data_1 = 20'h0AAAA; in_data_2 = 20'h00001;
        k = 0;
        while (k < 100 && out_valid !== 1'b1) begin
            if (out_data !== '0 || out_sat !== 1'b0 || out_dbz !== 1'b0) o.dirty = 1'b1;
            if (k == injectAt) begin
                in_valid = 1'b1; in_data_1 = 20'h00001; in_data_2 = 20'h00003;
            end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            k++;
        end
        if (out_valid === 1'b1) begin
            o.lat = k + 1; o.data = out_data; o.sat = out_sat; o.dbz = out_dbz;
            o.readyDone = in_ready;
        end
        if (injectDone) begin
            in_valid = 1'b1; in_data_1 = 20'h00400; in_data_2 = 20'h00400;
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        o.readyAfter = in_ready; o.validAfter = out_valid; o.dataAfter = out_data;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            out_sat !== 1'b0 || out_dbz !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: ready=%b valid=%b data=%h sat=%b dbz=%b ovr=%b, required 1 0 00000 0 0 0",
                     in_ready, out_valid, out_data, out_sat, out_dbz, overrun);
        end
    endtask

    task automatic test_divide();
        logic [DW-1:0] va [5] = '{20'h01000, 20'h00400, 20'h00000, 20'h12345, 20'hFFC00};
        logic [DW-1:0] vb [5] = '{20'h00800, 20'h00C00, 20'h00C00, 20'h12345, 20'h00400};
        logic [DW-1:0] ve [5] = '{20'h00800, 20'h00155, 20'h00000, Q_ONE,     20'hFFC00};
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], -1, 1'b0, o);
            checks++;
            if (o.lat !== 31) begin
                errors++;
                $display("[TB] FAIL div%0d latency: got %0d, required 31", i, o.lat);
            end
            checks++;
            if (o.data !== ve[i] || o.sat !== 1'b0 || o.dbz !== 1'b0) begin
                errors++;
                $display("[TB] FAIL div%0d result: got %h sat=%b dbz=%b, required %h sat=0 dbz=0",
                         i, o.data, o.sat, o.dbz, ve[i]);
            end
            checks++;
            if (o.startReady !== 1'b1 || o.readyDone !== 1'b0 || o.readyAfter !== 1'b1 ||
                o.validAfter !== 1'b0 || o.dataAfter !== '0 || o.dirty !== 1'b0) begin
                errors++;
                $display("[TB] FAIL div%0d handshake: start=%b done=%b after=%b vAfter=%b dAfter=%h dirty=%b, required 1 0 1 0 00000 0",
                         i, o.startReady, o.readyDone, o.readyAfter, o.validAfter, o.dataAfter, o.dirty);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_overrun: got %b, required 0", overrun);
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        run_op(20'hFFC00, 20'h00200, -1, 1'b0, o);
        checks++;
        if (o.lat !== 31 || o.data !== 20'hFFFFF || o.sat !== 1'b1 || o.dbz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL saturation: lat=%0d data=%h sat=%b dbz=%b, required 31 fffff 1 0",
                     o.lat, o.data, o.sat, o.dbz);
        end
        checks++;
        if (o.validAfter !== 1'b0 || o.dataAfter !== '0 || out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_clear: valid=%b data=%h sat=%b, required 0 00000 0",
                     o.validAfter, o.dataAfter, out_sat);
        end
    endtask

    task automatic test_dbz();
        obs_t o;
        run_op(20'h00A00, 20'h00000, -1, 1'b0, o);
        checks++;
        if (o.lat !== 1 || o.data !== 20'hFFFFF || o.dbz !== 1'b1 || o.sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz: lat=%0d data=%h dbz=%b sat=%b, required 1 fffff 1 0",
                     o.lat, o.data, o.dbz, o.sat);
        end
        checks++;
        if (o.readyDone !== 1'b0 || o.readyAfter !== 1'b1 || out_dbz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz_ready: done=%b after=%b dbz=%b, required 0 1 0",
                     o.readyDone, o.readyAfter, out_dbz);
        end
    endtask

    task automatic test_overrun();
        obs_t o;
        run_op(20'h01000, 20'h00800, 4, 1'b0, o);
        checks++;
        if (o.lat !== 31 || o.data !== 20'h00800 || o.sat !== 1'b0 || o.dbz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_result: lat=%0d data=%h sat=%b dbz=%b, required 31 00800 0 0",
                     o.lat, o.data, o.sat, o.dbz);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_set: got %b, required 1", overrun);
        end
        run_op(20'h00400, 20'h00C00, -1, 1'b0, o);
        checks++;
        if (overrun !== 1'b1 || o.data !== 20'h00155) begin
            errors++;
            $display("[TB] FAIL overrun_sticky: ovr=%b data=%h, required 1 00155", overrun, o.data);
        end
    endtask

    task automatic test_done_overrun();
        obs_t o;
        apply_reset();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_reset: got %b, required 0", overrun);
        end
        run_op(20'h00800, 20'h00400, -1, 1'b1, o);
        checks++;
        if (overrun !== 1'b1 || o.data !== 20'h00800) begin
            errors++;
            $display("[TB] FAIL done_overrun: ovr=%b data=%h, required 1 00800", overrun, o.data);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_ignored: ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        obs_t o;
        bit seen;
        in_valid = 1'b1; in_data_1 = 20'h01000; in_data_2 = 20'h00800;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || overrun !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: ready=%b valid=%b ovr=%b data=%h, required 1 0 0 00000",
                     in_ready, out_valid, overrun, out_data);
        end
        seen = 1'b0;
        repeat (35) begin
            @(posedge clk); @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL mid_reset_abandon: activity after reset, required none");
        end
        run_op(20'h00800, 20'h00400, -1, 1'b0, o);
        checks++;
        if (o.lat !== 31 || o.data !== 20'h00800 || o.sat !== 1'b0 || o.dbz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_op: lat=%0d data=%h sat=%b dbz=%b, required 31 00800 0 0",
                     o.lat, o.data, o.sat, o.dbz);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        run_op(20'h00C00, 20'h00400, -1, 1'b0, o1);
        run_op(20'h00001, 20'h00800, -1, 1'b0, o2);
        checks++;
        if (o1.data !== 20'h00C00 || o1.lat !== 31) begin
            errors++;
            $display("[TB] FAIL b2b_first: data=%h lat=%0d, required 00c00 31", o1.data, o1.lat);
        end
        checks++;
        if (o2.startReady !== 1'b1 || o2.data !== 20'h00000 || o2.lat !== 31) begin
            errors++;
            $display("[TB] FAIL b2b_second: start=%b data=%h lat=%0d, required 1 00000 31",
                     o2.startReady, o2.data, o2.lat);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data_1 = '0; in_data_2 = '0;
        @(negedge clk);
        test_reset();
        test_divide();
        test_saturation();
        test_dbz();
        test_overrun();
        test_done_overrun();
        test_reset_mid_div();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
